// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls one BURST_LEN-beat burst from a show-ahead FIFO into a registered valid/ready output.
// Defining FIFO_BURST_READER_ABORT_EN adds an abort input that cuts a running burst short.
module fifo_burst_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
`ifdef FIFO_BURST_READER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done
);
    localparam int RW = $clog2(BURST_LEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t        state;
    logic [RW-1:0] remaining;
    logic          abort_run;
`ifdef FIFO_BURST_READER_ABORT_EN
    assign abort_run = abort && state == RUN;
`else
    assign abort_run = 1'b0;
`endif
    assign fifo_pop = state == RUN && remaining != '0 && !fifo_empty && (!m_valid || m_ready) && !abort_run;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fifo_pop) begin
                m_data    <= fifo_dout;
                m_valid   <= 1'b1;
                m_last    <= remaining == RW'(1);
                remaining <= remaining - RW'(1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    remaining <= RW'(BURST_LEN);
                    busy      <= 1'b1;
                end
                RUN: if (abort_run) begin
                    remaining <= '0;
                    // a beat still waiting downstream becomes the final one; otherwise finish now
                    if (m_valid && !m_ready) begin
                        m_last <= 1'b1;
                        state  <= DRAIN;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else if (fifo_pop && remaining == RW'(1)) begin
                    state <= DRAIN;
                end
                DRAIN: if (m_valid && m_ready && m_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: FIFO model plus beat scoreboard around fifo_burst_reader.
module tb_fifo_burst_reader;
    localparam int W  = 32;
    localparam int BL = 4;
    typedef struct {
        int pre;
        int late;
        int rdy;
        bit restart;
        int exp_beats;
        int exp_done;
        int exp_left;
    } vec_t;
    logic clk = 0, rstn = 0, start = 0, m_ready = 0;
    logic fifo_empty, fifo_pop, m_valid, m_last, busy, done;
    logic [W-1:0] fifo_dout, m_data;
`ifdef FIFO_BURST_READER_ABORT_EN
    logic abort = 0;
`endif
    logic [W-1:0] mem [1024];
    int wr = 0, rd = 0;
    int n_checks = 0, n_fail = 0;
    int exp_idx = 0, beat = 0, acc_total = 0, done_cnt = 0;
    bit abort_last = 0;
    vec_t vecs [6];

    fifo_burst_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .rstn(rstn), .start(start),
`ifdef FIFO_BURST_READER_ABORT_EN
        .abort(abort),
`endif
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign fifo_empty = wr == rd;
    assign fifo_dout  = mem[rd[9:0]];
    always @(posedge clk) if (fifo_pop) rd <= rd + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        mem[wr[9:0]] = v;
        wr++;
    endtask

    // every accepted beat must be the next FIFO entry in write order; last on beat BL of a burst
    task automatic monitor();
        logic pv = 0, pr = 0, pacc_last = 0;
        logic [W-1:0] pd = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pv = 0;
                pacc_last = 0;
                continue;
            end
            check("pop_when_empty", fifo_pop & fifo_empty, 0);
            check("done_timing", done, pacc_last);
            if (pv && !pr) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, pd);
            end
            pacc_last = 0;
            if (m_valid && m_ready) begin
                beat++;
                check("beat_data", m_data, mem[exp_idx[9:0]]);
                check("beat_last", m_last, beat == BL || abort_last);
                exp_idx++;
                acc_total++;
                pacc_last = m_last;
                if (m_last) beat = 0;
            end
            if (done) done_cnt++;
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
        end
    endtask

    task automatic wait_done(input string name, input int d0);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        check({name, "_done"}, done_cnt - d0, 1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int b0 = acc_total, d0 = done_cnt;
        for (int i = 0; i < v.pre; i++) push($urandom);
        m_ready = 1;
        start = 1;
        tick();
        for (int c = 0; c < 300 && done_cnt == d0; c++) begin
            if (c == v.late) for (int j = 0; j < BL - v.pre; j++) push($urandom);
            start = v.restart && c == 2;
            m_ready = $urandom_range(99) < v.rdy;
            tick();
        end
        start = 0;
        m_ready = 1;
        repeat (5) tick();
        check({name, "_beats"}, acc_total - b0, v.exp_beats);
        check({name, "_dones"}, done_cnt - d0, v.exp_done);
        check({name, "_left"}, wr - rd, v.exp_left);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [W-1:0] val [4];
        int b0, d0, base;
        vecs[0] = '{4, 0, 100, 0, BL, 1, 0};
        vecs[1] = '{2, 5, 100, 0, BL, 1, 0};
        vecs[2] = '{4, 0, 100, 1, BL, 1, 0};
        vecs[3] = '{0, 3, 100, 0, BL, 1, 0};
        vecs[4] = '{4, 0, 40, 0, BL, 1, 0};
        vecs[5] = '{1, 8, 60, 1, BL, 1, 0};
        foreach (mem[i]) mem[i] = '0;
        fork
            monitor();
        join_none
        #1;
        check("rst_pop", fifo_pop, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) tick();
        rstn = 1;
        tick();

        // streaming: cycle-exact pops, data, last and done
        for (int i = 0; i < 4; i++) begin
            val[i] = 32'hA0A0_0000 + i;
            push(val[i]);
        end
        m_ready = 1;
        start = 1;
        tick();
        start = 0;
        check("str_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("str_pop%0d", i), fifo_pop, 1);
            tick();
            check($sformatf("str_valid%0d", i), m_valid, 1);
            check($sformatf("str_data%0d", i), m_data, val[i]);
            check($sformatf("str_last%0d", i), m_last, i == 3);
        end
        check("str_pop_end", fifo_pop, 0);
        check("str_done_early", done, 0);
        tick();
        check("str_done", done, 1);
        check("str_idle", busy, 0);
        tick();
        check("str_done_pulse", done, 0);

        // backpressure right after the first beat
        b0 = acc_total;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            val[i] = 32'hB0B0_0000 + i;
            push(val[i]);
        end
        start = 1;
        tick();
        start = 0;
        m_ready = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", m_valid, 1);
            check("bp_data", m_data, val[0]);
            check("bp_pop", fifo_pop, 0);
            tick();
        end
        m_ready = 1;
        wait_done("bp", d0);
        check("bp_beats", acc_total - b0, 4);

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);
        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v.pre = $urandom_range(0, BL);
            v.late = $urandom_range(0, 10);
            v.rdy = $urandom_range(30, 100);
            v.restart = 1'($urandom_range(0, 1));
            v.exp_beats = BL;
            v.exp_done = 1;
            v.exp_left = 0;
            run_vec($sformatf("rnd%0d", i), v);
        end

        // reset mid-RUN discards the beat in flight and never signals done
        for (int i = 0; i < 4; i++) push($urandom);
        m_ready = 1;
        start = 1;
        tick();
        start = 0;
        tick();
        #2 rstn = 0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_pop", fifo_pop, 0);
        check("mid_rst_busy", busy, 0);
        d0 = done_cnt;
        repeat (2) tick();
        rstn = 1;
        wr = rd;
        exp_idx = rd;
        beat = 0;
        repeat (4) tick();
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle", busy, 0);

`ifdef FIFO_BURST_READER_ABORT_EN
        // abort while the second beat is held
        b0 = acc_total;
        d0 = done_cnt;
        base = wr;
        for (int i = 0; i < 4; i++) push(32'hC0C0_0000 + i);
        m_ready = 1;
        start = 1;
        tick();
        start = 0;
        repeat (2) tick();
        m_ready = 0;
        abort = 1;
        abort_last = 1;
        #1 check("ab_no_pop", fifo_pop, 0);
        tick();
        abort = 0;
        check("ab_valid", m_valid, 1);
        check("ab_data", m_data, mem[base + 1]);
        check("ab_last", m_last, 1);
        check("ab_pop", fifo_pop, 0);
        m_ready = 1;
        wait_done("ab", d0);
        abort_last = 0;
        repeat (3) tick();
        check("ab_beats", acc_total - b0, 2);
        check("ab_dones", done_cnt - d0, 1);
        check("ab_left", wr - rd, 2);
        check("ab_idle", busy, 0);
        wr = rd;
        exp_idx = rd;
`else
        base = 0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width of the FIFO and the output bus.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, the beats per burst; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a pulse requesting one burst.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: the empty flag of the upstream sync FIFO.
REQ-007 The block SHALL have port fifo_dout, input, WIDTH bits: the upstream FIFO show-ahead head data, valid whenever fifo_empty=0.
REQ-008 The block SHALL have port fifo_pop, output, 1 bit: the pop strobe to the FIFO.
REQ-009 The block SHALL have port m_valid, output, 1 bit: output data valid.
REQ-010 The block SHALL have port m_ready, input, 1 bit: the downstream accept.
REQ-011 The block SHALL have port m_data, output, WIDTH bits: the output data.
REQ-012 The block SHALL have port m_last, output, 1 bit: marks the final beat of the burst.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a burst completes.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-016 In IDLE, start=1 SHALL move the FSM to RUN, load the remaining-beat counter with BURST_LEN, and set busy=1 from the next cycle.
REQ-017 When the FSM is not in IDLE, start SHALL be ignored; it SHALL not queue.
REQ-018 The output stage SHALL be one register stage. Define can_pop = (state==RUN) & (remaining>0) & !fifo_empty & (!m_valid | m_ready).
REQ-019 fifo_pop SHALL be combinational and equal to can_pop.
REQ-020 When can_pop=1, the block SHALL, on the next edge, set m_data=fifo_dout and m_valid=1, and decrement remaining by 1.
REQ-021 Latency from pop to m_valid SHALL be 1 cycle.
REQ-022 When m_ready stays 1 and the FIFO is non-empty, throughput SHALL be one beat per cycle.
REQ-023 m_valid SHALL fall only after an m_valid & m_ready accept with no new pop in that cycle. m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 m_last SHALL be 1 exactly on the beat loaded when remaining==1 is popped.
REQ-025 When the final pop occurs, RUN SHALL move to DRAIN.
REQ-026 In DRAIN, an m_valid & m_ready & m_last accept SHALL move the FSM to IDLE and pulse done=1 for exactly one cycle, on the cycle after the accept.
REQ-027 When fifo_empty=1 in RUN, the FSM SHALL stall with no pop and no timeout.
REQ-028 A fifo_empty deassertion SHALL allow a pop in that same cycle.
REQ-029 The block SHALL never pop when fifo_empty=1 and SHALL never pop more than BURST_LEN entries per burst.
REQ-030 The remaining counter SHALL be $clog2(BURST_LEN+1) bits wide and SHALL never underflow.
REQ-031 When BURST_LEN=1, a single pop SHALL both set m_last and move the FSM to DRAIN.

Reset
REQ-032 When rstn=0, the block SHALL asynchronously set state=IDLE, remaining=0, m_valid=0, m_data=0, m_last=0, done=0 and busy=0, and fifo_pop SHALL be 0.
REQ-033 On a reset during RUN or DRAIN, the beat in flight SHALL be discarded, no done pulse SHALL be produced, and the FSM SHALL restart from IDLE.

Configuration
REQ-034 The macro FIFO_BURST_READER_ABORT_EN SHALL control the abort feature.
REQ-035 With FIFO_BURST_READER_ABORT_EN defined, the block SHALL have an extra input port abort, 1 bit.
REQ-036 With the macro defined, abort=1 in RUN SHALL stop all further pops that cycle.
REQ-037 With the macro defined and m_valid=1 on an abort, the held beat SHALL have m_last forced to 1 and the FSM SHALL go to DRAIN.
REQ-038 With the macro defined and m_valid=0 on an abort, the FSM SHALL go directly to IDLE with a done pulse on the next cycle.
REQ-039 With the macro defined, abort SHALL be ignored in IDLE and DRAIN.
REQ-040 Without FIFO_BURST_READER_ABORT_EN, the abort port SHALL not exist and bursts SHALL always deliver BURST_LEN beats.

Verification
REQ-041 The bench SHALL cover reset: rstn low mid-RUN -> m_valid=0, fifo_pop=0, busy=0 immediately; no done pulse.
REQ-042 The bench SHALL cover a streaming burst: BURST_LEN=4, FIFO holds A,B,C,D, m_ready=1, start pulse -> fifo_pop high 4 consecutive cycles; m_data A..D on consecutive cycles; m_last only on D; done 1 cycle after D is accepted.
REQ-043 The bench SHALL cover backpressure: m_ready=0 for 3 cycles after the first beat -> m_data=A held stable; fifo_pop=0 throughout; no beat lost or duplicated.
REQ-044 The bench SHALL cover FIFO underrun: 2 entries present, the other 2 written 5 cycles later -> the block stalls in RUN without popping while empty; the burst completes with exactly 4 beats.
REQ-045 The bench SHALL cover start while busy: a second start during RUN -> ignored; exactly 4 beats delivered and one done pulse.
REQ-046 The bench SHALL cover abort (FIFO_BURST_READER_ABORT_EN defined): abort during the second beat with m_ready=0 -> the second beat is delivered with m_last=1; the FIFO retains the remaining 2 entries; one done pulse.
